arb_rr_4: RTL and testbench



---
 rtl/arb_rr_4.sv | 93 +++++++++
 tb/tb_arb_rr_4.sv | 99 +++++++++
 2 files changed

// File: rtl/arb_rr_4.sv
// arb_rr_4: four-requester round-robin arbiter with grant hold and optional hold-limit preemption
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   req      request vector, req[i] = requester i wants the resource
//   gnt      registered one-hot grant
//   gnt_id   registered binary index of the owner, 0 when idle
//   gnt_v    high while any grant is active
//   preempt  one-cycle pulse when the owner lost the grant to the hold limit
//
// Build option: define ARB_TIMEOUT_EN to revoke a grant after HOLD_MAX
// consecutive cycles while other requesters wait; otherwise preempt stays 0.
module arb_rr_4 #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_v,
    output logic       preempt
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d, cand;
    logic [1:0]       id_q, id_d, ptr_q, ptr_d, win;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             pre_q, pre_d, found, to;
`ifdef ARB_TIMEOUT_EN
    assign to = state_q == BUSY && hold_q == CNT_W'(HOLD_MAX) && (req & ~gnt_q) != 4'b0000;
`else
    assign to = 1'b0;
`endif
    // a preempted owner sits out the arbitration that replaces it
    assign cand  = to ? req & ~gnt_q : req;
    assign found = |cand;
    // scan from the far end so the index closest to ptr wins last
    always_comb begin
        win = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (cand[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
        end
    end
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        pre_d   = 1'b0;
        if (state_q == IDLE || !req[id_q] || to) begin
            if (found) begin
                state_d = BUSY;
                gnt_d   = 4'(1) << win;
                id_d    = win;
                ptr_d   = win + 2'd1;
                hold_d  = CNT_W'(1);
                pre_d   = to;
            end else begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                id_d    = 2'd0;
                hold_d  = '0;
            end
        end else begin
            hold_d = hold_q == CNT_W'(HOLD_MAX) ? hold_q : hold_q + CNT_W'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            id_q    <= 2'd0;
            ptr_q   <= 2'd0;
            hold_q  <= '0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            pre_q   <= pre_d;
        end
    end
    assign gnt     = gnt_q;
    assign gnt_id  = id_q;
    assign gnt_v   = |gnt_q;
    assign preempt = pre_q;
endmodule

// File: tb/tb_arb_rr_4.sv
// tb_arb_rr_4: vector table and scoreboard bench for the round-robin arbiter
module tb_arb_rr_4;
    typedef struct {
        logic       r;
        logic [3:0] req;
        logic [3:0] g;
        logic [1:0] id;
    } vec_t;
    typedef struct {
        logic [3:0] g;
        logic [1:0] id;
        logic       p;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_v, preempt;
    int         checks = 0;
    int         errors = 0;
    exp_t       sb[$];
    vec_t       tbl[32];
    arb_rr_4 #(.HOLD_MAX(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .gnt_id(gnt_id), .gnt_v(gnt_v), .preempt(preempt)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input int step_no, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b expected %b", name, step_no, act, exp);
        end
    endtask
    task automatic step(input int n, input logic r, input logic [3:0] rq, input logic [3:0] g, input logic [1:0] id, input logic p);
        exp_t e;
        rst = r;
        req = rq;
        sb.push_back('{g, id, p});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("gnt", n, gnt, e.g);
        chk("gnt_id", n, {2'b00, gnt_id}, {2'b00, e.id});
        chk("gnt_v", n, {3'b000, gnt_v}, {3'b000, |e.g});
        chk("preempt", n, {3'b000, preempt}, {3'b000, e.p});
        chk("onehot", n, {3'b000, $onehot0(gnt)}, 4'b0001);
    endtask
    initial begin
        tbl = '{
            '{1'b1, 4'b1111, 4'b0000, 2'd0},
            '{1'b1, 4'b1111, 4'b0000, 2'd0},
            '{1'b0, 4'b1111, 4'b0001, 2'd0},
            '{1'b0, 4'b1111, 4'b0001, 2'd0},
            '{1'b0, 4'b1110, 4'b0010, 2'd1},
            '{1'b0, 4'b1111, 4'b0010, 2'd1},
            '{1'b0, 4'b1101, 4'b0100, 2'd2},
            '{1'b0, 4'b1111, 4'b0100, 2'd2},
            '{1'b0, 4'b1011, 4'b1000, 2'd3},
            '{1'b0, 4'b1111, 4'b1000, 2'd3},
            '{1'b0, 4'b0111, 4'b0001, 2'd0},
            '{1'b0, 4'b0000, 4'b0000, 2'd0},
            '{1'b0, 4'b0100, 4'b0100, 2'd2},
            '{1'b0, 4'b0100, 4'b0100, 2'd2},
            '{1'b0, 4'b0100, 4'b0100, 2'd2},
            '{1'b0, 4'b0100, 4'b0100, 2'd2},
            '{1'b0, 4'b0100, 4'b0100, 2'd2},
            '{1'b0, 4'b0000, 4'b0000, 2'd0},
            '{1'b0, 4'b0101, 4'b0001, 2'd0},
            '{1'b0, 4'b0000, 4'b0000, 2'd0},
            '{1'b0, 4'b0010, 4'b0010, 2'd1},
            '{1'b0, 4'b0000, 4'b0000, 2'd0},
            '{1'b0, 4'b1010, 4'b1000, 2'd3},
            '{1'b0, 4'b0000, 4'b0000, 2'd0},
            '{1'b0, 4'b0100, 4'b0100, 2'd2},
            '{1'b0, 4'b0100, 4'b0100, 2'd2},
            '{1'b1, 4'b0100, 4'b0000, 2'd0},
            '{1'b0, 4'b0110, 4'b0010, 2'd1},
            '{1'b0, 4'b0011, 4'b0010, 2'd1},
            '{1'b0, 4'b0001, 4'b0001, 2'd0},
            '{1'b0, 4'b0011, 4'b0001, 2'd0},
            '{1'b0, 4'b0000, 4'b0000, 2'd0}
        };
        for (int i = 0; i < 32; i++) step(i, tbl[i].r, tbl[i].req, tbl[i].g, tbl[i].id, 1'b0);
`ifdef ARB_TIMEOUT_EN
        step(100, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) step(101 + i, 1'b0, 4'b0011, 4'b0001, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) step(105 + i, 1'b0, 4'b0011, 4'b0010, 2'd1, i == 0);
        step(109, 1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1);
        for (int i = 0; i < 10; i++) step(110 + i, 1'b0, 4'b0001, 4'b0001, 2'd0, 1'b0);
`else
        step(100, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
        for (int i = 0; i < 12; i++) step(101 + i, 1'b0, 4'b0011, 4'b0001, 2'd0, 1'b0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
